// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the EX-stage ALU controller and its multiply/divide engine.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100, ALU_SRL  = 4'b0101, ALU_SUB  = 4'b0110, ALU_SRA  = 4'b0111,
    ALU_BEQ  = 4'b1000, ALU_BLT  = 4'b1001, ALU_BGE  = 4'b1010, ALU_BNE  = 4'b1011,
    ALU_SLT  = 4'b1100, ALU_SLTU = 4'b1101, ALU_BLTU = 4'b1110, ALU_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} md_state_e;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_JUMP   = 2'b11;

  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  function automatic logic op_signed_a(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_signed_b(md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic op_is_div(md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/seq_muldiv_dp.sv
// Magnitude shift-add multiplier / restoring divider sharing one XLEN+1 adder.
// The divide step is only reachable when ALU_MULDIV_DIV_EN is defined.
module seq_muldiv_dp
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            fast,
  input  logic            iter,
  input  logic            finish,
  input  md_op_e          op,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic [XLEN-1:0] md_result
);

  logic [2*XLEN-1:0] acc_reg, acc_next, prod_fix;
  logic [XLEN-1:0]   opb_reg, md_result_reg;
  logic [XLEN-1:0]   abs_a, abs_b, div_raw, fin_result, fast_result;
  md_op_e            op_reg;
  logic              neg_reg, a_neg, b_neg, div_mode;
  logic [XLEN:0]     add_a, add_b;
  logic [XLEN+1:0]   sum;

  assign a_neg = op_signed_a(op) & srca[XLEN-1];
  assign b_neg = op_signed_b(op) & srcb[XLEN-1];
  assign abs_a = a_neg ? -srca : srca;
  assign abs_b = b_neg ? -srcb : srcb;

`ifdef ALU_MULDIV_DIV_EN
  assign div_mode = op_is_div(op_reg);
`else
  assign div_mode = 1'b0;
`endif

  // Multiply adds the multiplicand to the upper half; divide subtracts the
  // divisor from the left-shifted remainder, carry-out meaning "no borrow".
  assign add_a = div_mode ? acc_reg[2*XLEN-1:XLEN-1] : {1'b0, acc_reg[2*XLEN-1:XLEN]};
  assign add_b = div_mode ? ~{1'b0, opb_reg} : {1'b0, opb_reg};
  assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, div_mode};

  always_comb begin
    if (div_mode) begin
      if (sum[XLEN+1]) acc_next = {sum[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
      else             acc_next = {acc_reg[2*XLEN-2:0], 1'b0};
    end else if (acc_reg[0]) begin
      acc_next = {sum[XLEN:0], acc_reg[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc_reg[2*XLEN-1:1]};
    end
  end

  assign prod_fix = neg_reg ? -acc_next : acc_next;
  assign div_raw  = op_reg[1] ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];

  always_comb begin
    if (div_mode)              fin_result = neg_reg ? -div_raw : div_raw;
    else if (op_reg == MD_MUL) fin_result = prod_fix[XLEN-1:0];
    else                       fin_result = prod_fix[2*XLEN-1:XLEN];
  end

  // Divide-by-zero and MIN/-1 answers; the quotient of MIN/-1 is SrcA itself.
  assign fast_result = op[1] ? ((srcb == '0) ? srca : {XLEN{1'b0}})
                             : ((srcb == '0) ? {XLEN{1'b1}} : srca);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg       <= '0;
      opb_reg       <= '0;
      op_reg        <= MD_MUL;
      neg_reg       <= 1'b0;
      md_result_reg <= '0;
    end else begin
      if (start) begin
        acc_reg <= {{XLEN{1'b0}}, abs_a};
        opb_reg <= abs_b;
        op_reg  <= op;
        neg_reg <= (op == MD_REM) ? a_neg : (a_neg ^ b_neg);
      end else if (iter) begin
        acc_reg <= acc_next;
      end
      if (finish)    md_result_reg <= fin_result;
      else if (fast) md_result_reg <= fast_result;
    end
  end

  assign md_result = md_result_reg;

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU op decoder with an iterative RV32M engine and stall handshake.
// Define ALU_MULDIV_DIV_EN to support DIV/DIVU/REM/REMU; otherwise they raise illegal.
module alu_muldiv_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic            RType,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic [3:0]      Operation,
  output logic            md_sel,
  output logic [XLEN-1:0] md_result,
  output logic            stall,
  output logic            illegal
);

  localparam int CNT_W = $clog2(XLEN);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             md_sel_reg;
  md_op_e           md_op;
  alu_op_e          op_next;
  logic             m_op, m_go, div_fast, iterating;
  logic             launch_fast, dp_start, dp_iter, dp_finish;

  assign md_op = md_op_e'(Funct3);
  assign m_op  = valid_in & (ALUOp == ALUOP_RTYPE) & RType & (Funct7 == FUNCT7_MULDIV);

`ifdef ALU_MULDIV_DIV_EN
  assign m_go     = m_op;
  assign illegal  = 1'b0;
  assign div_fast = (SrcB == '0) |
                    ((md_op inside {MD_DIV, MD_REM}) &
                     (SrcA == {1'b1, {(XLEN-1){1'b0}}}) & (SrcB == {XLEN{1'b1}}));
`else
  assign m_go     = m_op & ~op_is_div(md_op);
  assign illegal  = m_op & op_is_div(md_op);
  assign div_fast = 1'b0;
`endif

  always_comb begin
    op_next = ALU_ADD;
    case (ALUOp)
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b001:  op_next = ALU_BNE;
          3'b100:  op_next = ALU_BLT;
          3'b101:  op_next = ALU_BGE;
          3'b110:  op_next = ALU_BLTU;
          3'b111:  op_next = ALU_BGEU;
          default: op_next = ALU_BEQ;
        endcase
      end
      ALUOP_RTYPE: begin
        case (Funct3)
          3'b000:  op_next = (RType && Funct7 == FUNCT7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  op_next = ALU_SLL;
          3'b010:  op_next = ALU_SLT;
          3'b011:  op_next = ALU_SLTU;
          3'b100:  op_next = ALU_XOR;
          3'b101:  op_next = (Funct7 == FUNCT7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  op_next = ALU_OR;
          default: op_next = ALU_AND;
        endcase
      end
      default: op_next = ALU_ADD;
    endcase
    if (m_op) op_next = ALU_ADD;
  end

  assign Operation = op_next;

  assign iterating   = (state_reg == ST_MUL) | (state_reg == ST_DIV);
  // Gated by reset so the hazard unit never sees a stall while the core is held.
  assign stall       = reset & ~flush & (((state_reg == ST_IDLE) & m_go) | iterating);
  assign md_sel      = md_sel_reg;

  assign launch_fast = (state_reg == ST_IDLE) & m_go & op_is_div(md_op) & div_fast & ~flush;
  assign dp_start    = (state_reg == ST_IDLE) & m_go & ~launch_fast & ~flush;
  assign dp_iter     = iterating & ~flush;
  assign dp_finish   = dp_iter & (cnt_reg == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      md_sel_reg <= 1'b0;
    end else if (flush) begin
      state_reg  <= ST_IDLE;
      md_sel_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (m_go) begin
            cnt_reg <= CNT_W'(XLEN-1);
            if (launch_fast) begin
              state_reg  <= ST_DONE;
              md_sel_reg <= 1'b1;
            end
`ifdef ALU_MULDIV_DIV_EN
            else if (op_is_div(md_op)) state_reg <= ST_DIV;
`endif
            else state_reg <= ST_MUL;
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_reg == '0) begin
            state_reg  <= ST_DONE;
            md_sel_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        // DONE retires the frozen instruction on this edge and never relaunches it.
        default: begin
          state_reg  <= ST_IDLE;
          md_sel_reg <= 1'b0;
        end
      endcase
    end
  end

  seq_muldiv_dp #(.XLEN(XLEN)) u_dp (
    .clk       (clk),
    .reset     (reset),
    .start     (dp_start),
    .fast      (launch_fast),
    .iter      (dp_iter),
    .finish    (dp_finish),
    .op        (md_op),
    .srca      (SrcA),
    .srcb      (SrcB),
    .md_result (md_result)
  );

endmodule
